// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Burst beat counter: cleared on accept, flags the final beat of a BEATS-long line.
module mem_arb_beat_ctr
  import mem_arb_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int CW = clog2(BEATS);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CW'(BEATS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between icache and dcache line transfers.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is dcache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        ic_req_valid,
  input  logic [31:0] ic_req_addr,
  output logic        ic_req_ready,
  output logic        ic_resp_valid,
  output logic [31:0] ic_resp_data,
  input  logic        dc_req_valid,
  input  logic        dc_req_rnw,
  input  logic [31:0] dc_req_addr,
  output logic        dc_req_ready,
  input  logic        dc_wdata_valid,
  input  logic [31:0] dc_wdata,
  output logic        dc_wdata_ready,
  output logic        dc_resp_valid,
  output logic [31:0] dc_resp_data,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_rnw,
  output logic [31:0] mem_cmd_addr,
  output logic        mem_wdata_valid,
  input  logic        mem_wdata_ready,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int          CW        = clog2(BEATS);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << (CW + 2)) - 32'd1);

  state_t      state;
  owner_t      owner;
  logic        cmd_vld_q, rnw_q;
  logic [31:0] addr_q, resp_data_q;
  logic        ic_rv_q, dc_rv_q;
  logic        idle, grant_ic, grant_dc, accept;
  logic        wr_hs, rd_beat, beat_inc, beat_last, beat_done;

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign idle = (state == IDLE) && reset_n;

`ifdef MEM_ARB_RR_EN
  logic rr_dc;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)    rr_dc <= 1'b1;
    else if (accept) rr_dc <= grant_ic;
  end

  assign grant_dc = idle && dc_req_valid && (!ic_req_valid || rr_dc);
`else
  assign grant_dc = idle && dc_req_valid;
`endif
  assign grant_ic = idle && ic_req_valid && !grant_dc;
  assign accept   = grant_ic || grant_dc;

  assign wr_hs     = (state == WDATA) && dc_wdata_valid && mem_wdata_ready;
  assign rd_beat   = (state == RDATA) && mem_rdata_valid;
  assign beat_inc  = wr_hs || rd_beat;
  assign beat_done = beat_inc && beat_last;

  mem_arb_beat_ctr #(.BEATS(BEATS)) u_beat_ctr (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clr     (accept),
    .inc     (beat_inc),
    .last    (beat_last)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= OWN_IC;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      cmd_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= CMD;
          cmd_vld_q <= 1'b1;
          owner     <= grant_dc ? OWN_DC : OWN_IC;
          rnw_q     <= grant_dc ? dc_req_rnw : 1'b1;
          addr_q    <= (grant_dc ? dc_req_addr : ic_req_addr) & LINE_MASK;
        end
        CMD: if (mem_cmd_ready) begin
          cmd_vld_q <= 1'b0;
          state     <= rnw_q ? RDATA : WDATA;
        end
        WDATA, RDATA: if (beat_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read beats are registered once and steered only to the owner's valid.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ic_rv_q     <= 1'b0;
      dc_rv_q     <= 1'b0;
      resp_data_q <= '0;
    end else begin
      ic_rv_q <= rd_beat && (owner == OWN_IC);
      dc_rv_q <= rd_beat && (owner == OWN_DC);
      if (rd_beat) resp_data_q <= mem_rdata;
    end
  end

  assign ic_req_ready    = grant_ic;
  assign dc_req_ready    = grant_dc;
  assign ic_resp_valid   = ic_rv_q;
  assign dc_resp_valid   = dc_rv_q;
  assign ic_resp_data    = resp_data_q;
  assign dc_resp_data    = resp_data_q;
  assign mem_cmd_valid   = cmd_vld_q;
  assign mem_cmd_rnw     = rnw_q;
  assign mem_cmd_addr    = addr_q;
  assign mem_wdata_valid = (state == WDATA) && dc_wdata_valid;
  assign mem_wdata       = (state == WDATA) ? dc_wdata : '0;
  assign dc_wdata_ready  = (state == WDATA) && mem_wdata_ready;
  assign busy            = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single backing-memory port between the instruction-cache and data-cache refill/writeback engines. Requests are line-sized bursts of BEATS 32-bit words. Each request is granted exclusively, and the arbiter sequences command, write-data and read-data phases. Read beats are routed back to the owner. The block sits between the two cache controllers and the memory interface, so a stalled pipeline resumes only after its line transfer completes.

## Interface
- BEATS, 4, words per burst; power of two, 2..16.
- CLK  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  icache line read request.
- ic_req_addr  in  32  icache request byte address.
- ic_req_ready  out  1  icache request accepted this cycle.
- ic_resp_valid  out  1  icache read beat valid.
- ic_resp_data  out  32  icache read beat data.
- dc_req_valid  in  1  dcache request.
- dc_req_rnw  in  1  1 = line read, 0 = line write.
- dc_req_addr  in  32  dcache request byte address.
- dc_req_ready  out  1  dcache request accepted this cycle.
- dc_wdata_valid  in  1  dcache write beat valid.
- dc_wdata  in  32  dcache write beat data.
- dc_wdata_ready  out  1  dcache write beat taken.
- dc_resp_valid  out  1  dcache read beat valid.
- dc_resp_data  out  32  dcache read beat data.
- mem_cmd_valid / mem_cmd_ready  out / in  1  memory command handshake.
- mem_cmd_rnw  out  1  command direction.
- mem_cmd_addr  out  32  line-aligned address.
- mem_wdata_valid / mem_wdata_ready  out / in  1  write beat handshake.
- mem_wdata  out  32  write beat data.
- mem_rdata_valid  in  1  read beat from memory (no backpressure).
- mem_rdata  in  32  read beat data.
- busy  out  1  a transfer is in flight (state is not IDLE).

## Operation
- **States**
  - IDLE → CMD on accept.
  - CMD → RDATA on cmd handshake with rnw = 1, or → WDATA with rnw = 0.
  - RDATA → IDLE after BEATS read beats.
  - WDATA → IDLE after BEATS write beats.
- **Accept (IDLE only)**
  - Pick a winner among the valid requests.
  - Assert that requester's *_req_ready combinationally. Only one ready is high in any cycle.
  - On accept, register owner, rnw (forced to 1 for icache) and the address with bits [log2(BEATS)+1:0] cleared.
- **CMD**
  - mem_cmd_valid = 1 with the registered fields.
  - Fields are held stable until mem_cmd_ready.
- **WDATA**
  - mem_wdata_valid = dc_wdata_valid; mem_wdata = dc_wdata; dc_wdata_ready = mem_wdata_ready.
  - All three are combinational pass-through.
  - The beat counter increments per handshake.
- **RDATA**
  - Each mem_rdata_valid beat is registered and presented to the owner's resp port only; the other resp_valid stays 0.
  - The counter increments per beat.
- **Beat counter**
  - log2(BEATS) bits, cleared on accept.
  - The last beat is when the counter equals BEATS-1 and a handshake or beat occurs; the state returns to IDLE that cycle.
- **Spurious inputs**
  - mem_rdata_valid outside RDATA is ignored.
  - dc_wdata_valid outside WDATA is never acknowledged.
- A requester must hold valid and fields until ready. The arbiter does not re-sample after accept.

## Timing
- **Reset:** state IDLE, counter 0, rr pointer favours dcache; every output is 0.
  - Reset mid-burst abandons the transfer with no completion signalled. The memory side must be reset together with the arbiter.
- **Latency**
  - Accept in cycle N → mem_cmd_valid from N+1.
  - Read beat in cycle M → *_resp_valid in M+1.
  - After the final beat, a new accept is possible in the following cycle. Back-to-back grant gap is 0 idle cycles beyond the IDLE cycle.
- **Simultaneous requests:** see Configuration.
- A requester that drops valid before ready is simply not granted.

## Configuration
- MEM_ARB_RR_EN
  - **Defined:** round-robin. When both are valid, grant the one not granted last. The rr pointer updates on each accept.
  - **Undefined:** fixed priority, dcache always wins. The icache waits while dc_req_valid is high. The rr pointer register is not built.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, CMD, WDATA, RDATA);
  - owner encoding (OWN_IC, OWN_DC);
  - a function clog2 for the counter width.
- One sub-module, mem_arb_beat_ctr: clear, increment and last-beat flag, parameterised by BEATS.
- Grant logic, FSM and routing stay in mem_arbiter.

## Test plan
- **icache read:** ic_req addr 0x0000_1234, BEATS = 4.
  - mem_cmd_addr 0x0000_1230 with rnw = 1, one cycle after accept.
  - 4 memory beats A0..A3 appear on ic_resp one cycle later each; dc_resp_valid stays 0; busy drops after the 4th beat.
- **dcache write with backpressure:** dc write 0x1000_0040 with mem_wdata_ready toggling 1,0,1,0.
  - Exactly 4 dc_wdata_ready pulses; mem_wdata matches D0..D3 in order; return to IDLE with no resp pulses.
- **Simultaneous requests:** both request in the same cycle, repeated 4 times.
  - Without MEM_ARB_RR_EN the grants are D, D, D, D.
  - With it, the grants are D, I, D, I.
- **Spurious read beat:** mem_rdata_valid pulsed in IDLE and during CMD → no resp_valid, counter unchanged.
- **Reset mid-burst:** reset_n low after 2 of 4 read beats.
  - All outputs 0 immediately (asynchronously).
  - After release, a new ic request is accepted in the first cycle.
- **Command stall:** mem_cmd_ready held low for 5 cycles → mem_cmd_valid, addr and rnw stay stable; no second ready is given to either requester.
